// File: rtl/lifo_pkg.sv
// lifo_pkg: shared defaults, state encoding and parameter check for the LIFO stack controller
package lifo_pkg;
  localparam int DATA_W_DEF = 11;
  localparam int DEPTH_DEF = 15;
  typedef enum logic [1:0] {IDLE, POP_WAIT, POP_CAP} lifo_ctrl_state_t;
  function automatic bit pop_lat_ok(input int lat);
    return lat >= 1 && lat <= 3;
  endfunction
endpackage

// File: rtl/lifo_ctrl.sv
// lifo_ctrl: turns a valid/ready push stream and pop requests into single-cycle stack strobes with occupancy and sticky error tracking
module lifo_ctrl
  import lifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int POP_LAT = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_data_valid,
  output logic              stk_wr_en,
  output logic              stk_rd_en,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err,
  input  logic              err_clr
);
  lifo_ctrl_state_t state, state_nxt;
  logic [1:0] settle;
  logic idle, pop_go, push_go, ovf_set, unf_set;
  if (!pop_lat_ok(POP_LAT)) begin : g_bad_lat
    $error("lifo_ctrl: POP_LAT must be 1..3");
  end
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  always_comb begin
    idle = state == IDLE;
    pop_ready = idle && !empty;
    push_ready = idle && !full && !(pop_req && !empty);
    pop_go = pop_req && pop_ready;
    push_go = push_valid && push_ready;
    ovf_set = idle && push_valid && full;
    unf_set = idle && pop_req && empty;
    state_nxt = state == IDLE ? (pop_go ? POP_WAIT : IDLE) :
                state == POP_WAIT ? (settle == '0 ? POP_CAP : POP_WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      settle <= '0;
      stk_wr_en <= 1'b0;
      stk_rd_en <= 1'b0;
      stk_din <= '0;
      pop_data <= '0;
      pop_data_valid <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count <= push_go ? count + 1'b1 : pop_go ? count - 1'b1 : count;
      settle <= pop_go ? 2'(POP_LAT - 1) : (state == POP_WAIT && settle != '0) ? settle - 2'd1 : settle;
      stk_wr_en <= push_go;
      stk_rd_en <= pop_go;
      stk_din <= push_go ? push_data : stk_din;
      pop_data <= state == POP_CAP ? stk_dout : pop_data;
      pop_data_valid <= state == POP_CAP;
      ovf_err <= ovf_set || (ovf_err && !err_clr);
      unf_err <= unf_set || (unf_err && !err_clr);
    end
endmodule

// File: tb/tb_lifo_ctrl.sv
// tb_lifo_ctrl: vector table, reference stack model and pop scoreboard for lifo_ctrl
module tb_lifo_ctrl;
  localparam int W = 11;
  localparam int D = 15;
  localparam int BUSY = 3;
  typedef struct {
    logic v;
    logic [W-1:0] d;
    logic r;
    logic c;
    logic [3:0] cnt;
    logic wr;
    logic rd;
    logic unf;
  } vec_t;
  logic clk = 1'b0;
  logic rst, rst3;
  always #5 clk = ~clk;
  logic pv, pr, ec, push_ready, pop_ready, pop_data_valid, stk_wr_en, stk_rd_en, full, empty, ovf_err, unf_err;
  logic [W-1:0] pd, pop_data, stk_din, stk_dout;
  logic [3:0] count;
  logic pv3, pr3, ec3, push_ready3, pop_ready3, pop_data_valid3, stk_wr_en3, stk_rd_en3, full3, empty3, ovf_err3, unf_err3;
  logic [W-1:0] pd3, pop_data3, stk_din3, stk_dout3;
  logic [3:0] count3;
  lifo_ctrl #(.DATA_W(W), .DEPTH(D), .POP_LAT(1)) dut (
    .clk(clk), .rst(rst), .push_valid(pv), .push_data(pd), .push_ready(push_ready),
    .pop_req(pr), .pop_ready(pop_ready), .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .stk_wr_en(stk_wr_en), .stk_rd_en(stk_rd_en), .stk_din(stk_din), .stk_dout(stk_dout),
    .count(count), .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(ec)
  );
  lifo_ctrl #(.DATA_W(W), .DEPTH(D), .POP_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .push_valid(pv3), .push_data(pd3), .push_ready(push_ready3),
    .pop_req(pr3), .pop_ready(pop_ready3), .pop_data(pop_data3), .pop_data_valid(pop_data_valid3),
    .stk_wr_en(stk_wr_en3), .stk_rd_en(stk_rd_en3), .stk_din(stk_din3), .stk_dout(stk_dout3),
    .count(count3), .full(full3), .empty(empty3), .ovf_err(ovf_err3), .unf_err(unf_err3), .err_clr(ec3)
  );
  logic [W-1:0] mem [16];
  logic [4:0] sp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sp <= '0;
      stk_dout <= '0;
    end else if (stk_wr_en) begin
      mem[sp[3:0]] <= stk_din;
      sp <= sp + 5'd1;
    end else if (stk_rd_en) begin
      stk_dout <= mem[sp[3:0] - 4'd1];
      sp <= sp - 5'd1;
    end
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] ref_q[$];
  logic [W-1:0] exp_q[$];
  vec_t tv[$];
  int busy;
  logic m_wr, m_rd, m_ovf, m_unf;
  logic [W-1:0] m_din;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    ref_q.delete();
    exp_q.delete();
    busy = 0;
    m_wr = 1'b0;
    m_rd = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_din = '0;
  endtask
  task automatic drive(input int v, input int d, input int r, input int c);
    logic idle, mt, mf, bv, br, bc;
    chk("stk_wr_en", stk_wr_en, m_wr);
    chk("stk_rd_en", stk_rd_en, m_rd);
    chk("stk_din", stk_din, m_din);
    chk("ovf_err", ovf_err, m_ovf);
    chk("unf_err", unf_err, m_unf);
    chk("pop_data_valid", pop_data_valid, busy == 1);
    chk("count", count, ref_q.size());
    if (busy > 0) busy--;
    idle = busy == 0;
    mt = ref_q.size() == 0;
    mf = ref_q.size() == D;
    bv = v != 0;
    br = r != 0;
    bc = c != 0;
    pv = bv;
    pd = W'(d);
    pr = br;
    ec = bc;
    #1;
    chk("push_ready", push_ready, idle && !mf && !(br && !mt));
    chk("pop_ready", pop_ready, idle && !mt);
    chk("full", full, mf);
    chk("empty", empty, mt);
    m_wr = idle && bv && !mf && !(br && !mt);
    m_rd = idle && br && !mt;
    m_ovf = (idle && bv && mf) || (m_ovf && !bc);
    m_unf = (idle && br && mt) || (m_unf && !bc);
    if (m_wr) begin
      ref_q.push_back(W'(d));
      m_din = W'(d);
    end
    if (m_rd) begin
      exp_q.push_back(ref_q.pop_back());
      busy = BUSY;
    end
  endtask
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    chk("strobe_exclusive", stk_wr_en && stk_rd_en, 0);
    if (pop_data_valid) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      chk("pop_data", pop_data, e);
    end
  endtask
  task automatic tick3();
    @(posedge clk);
    #1;
  endtask
  task automatic reset1();
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_wr", stk_wr_en, 0);
    chk("rst_rd", stk_rd_en, 0);
    chk("rst_valid", pop_data_valid, 0);
    chk("rst_ovf", ovf_err, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick3();
  endtask
  task automatic add(input int v, input int d, input int r, input int c, input int cnt, input int wr, input int rd, input int unf);
    tv.push_back('{v != 0, W'(d), r != 0, c != 0, 4'(cnt), wr != 0, rd != 0, unf != 0});
  endtask
  initial begin
    pv = 1'b0; pd = '0; pr = 1'b0; ec = 1'b0;
    pv3 = 1'b0; pd3 = '0; pr3 = 1'b0; ec3 = 1'b0; stk_dout3 = '0;
    rst = 1'b1;
    rst3 = 1'b1;
    model_reset();
    add(1, 'h001, 0, 0, 1, 1, 0, 0);
    add(1, 'h002, 0, 0, 2, 1, 0, 0);
    add(1, 'h003, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 'h2AA, 0, 0, 2, 1, 0, 0);
    add(1, 'h155, 1, 0, 1, 0, 1, 0);
    add(1, 'h155, 0, 0, 1, 0, 0, 0);
    add(1, 'h155, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(1, 'h077, 1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_strobes", {stk_wr_en, stk_rd_en, pop_data_valid}, 0);
    chk("reset_din", stk_din, 0);
    chk("reset_pop_data", pop_data, 0);
    chk("reset_errs", {ovf_err, unf_err}, 0);
    chk("reset_push_ready", push_ready, 1);
    chk("reset_pop_ready", pop_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    rst3 = 1'b0;
    tick3();
    for (int i = 0; i < tv.size(); i++) begin
      drive(int'(tv[i].v), int'(tv[i].d), int'(tv[i].r), int'(tv[i].c));
      tick();
      chk("tv_count", count, tv[i].cnt);
      chk("tv_wr_en", stk_wr_en, tv[i].wr);
      chk("tv_rd_en", stk_rd_en, tv[i].rd);
      chk("tv_unf_err", unf_err, tv[i].unf);
    end
    chk("pop_data_held", pop_data, 'h001);
    reset1();
    for (int i = 0; i < D; i++) begin
      drive(1, 'h100 + i, 0, 0);
      tick();
    end
    drive(1, 'h1FF, 0, 0);
    chk("full_flag", full, 1);
    chk("full_push_ready", push_ready, 0);
    tick();
    chk("ovf_set", ovf_err, 1);
    chk("ovf_count", count, D);
    chk("ovf_no_wr", stk_wr_en, 0);
    drive(0, 0, 0, 1);
    tick();
    chk("ovf_clear", ovf_err, 0);
    for (int i = 0; i < D * BUSY; i++) begin
      drive(0, 0, 1, 0);
      tick();
    end
    repeat (3) begin
      drive(0, 0, 0, 0);
      tick();
    end
    chk("drain_full_scoreboard", exp_q.size(), 0);
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 2047),
            ((i / 500) % 2 != 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 31) == 0));
      tick();
    end
    repeat (4) begin
      drive(0, 0, 0, 0);
      tick();
    end
    chk("drain_random_scoreboard", exp_q.size(), 0);
    pv3 = 1'b1;
    pd3 = 'h0AB;
    tick3();
    pv3 = 1'b0;
    chk("l3_push_count", count3, 1);
    chk("l3_push_wr", stk_wr_en3, 1);
    pr3 = 1'b1;
    #1;
    chk("l3_pop_ready", pop_ready3, 1);
    tick3();
    pr3 = 1'b0;
    stk_dout3 = 'h3C3;
    chk("l3_rd_en", stk_rd_en3, 1);
    chk("l3_pop_count", count3, 0);
    for (int k = 2; k <= 4; k++) begin
      tick3();
      chk("l3_wait_valid", pop_data_valid3, 0);
      chk("l3_wait_rd", stk_rd_en3, 0);
    end
    tick3();
    chk("l3_valid", pop_data_valid3, 1);
    chk("l3_pop_data", pop_data3, 'h3C3);
    tick3();
    chk("l3_valid_pulse", pop_data_valid3, 0);
    pv3 = 1'b1;
    pd3 = 'h055;
    tick3();
    pv3 = 1'b0;
    pr3 = 1'b1;
    tick3();
    pr3 = 1'b0;
    chk("l3_second_rd", stk_rd_en3, 1);
    tick3();
    rst3 = 1'b1;
    #1;
    chk("l3_rst_valid", pop_data_valid3, 0);
    chk("l3_rst_count", count3, 0);
    chk("l3_rst_strobes", {stk_wr_en3, stk_rd_en3}, 0);
    chk("l3_rst_pop_data", pop_data3, 0);
    chk("l3_rst_din", stk_din3, 0);
    chk("l3_rst_errs", {ovf_err3, unf_err3}, 0);
    chk("l3_rst_ready", {push_ready3, pop_ready3}, 2'b10);
    tick3();
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick3();
      chk("l3_abandoned_valid", pop_data_valid3, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
